// File: rtl/door_step_if.sv
// Sensor/monitor bundle for the door step scheduler.
// The master drives the door events and the control strobes.
// The slave (the scheduler) returns the handshake, the committed counts and the status.
interface door_step_if #(
    parameter int NDOORS  = 3,
    parameter int WORDLEN = 10
);
    logic [NDOORS-1:0]             door_valid;
    logic [2*NDOORS-1:0]           door_evt;
    logic [NDOORS-1:0]             door_ready;
    logic                          step_req;
    logic                          clear_fault;
    logic [WORDLEN-1:0]            cnt_a;
    logic [WORDLEN-1:0]            cnt_b;
    logic                          fault;
    logic                          step_done;
    logic [4*WORDLEN*NDOORS-1:0]   system_vec;

    modport master (
        output door_valid, door_evt, step_req, clear_fault,
        input  door_ready, cnt_a, cnt_b, fault, step_done, system_vec
    );

    modport slave (
        input  door_valid, door_evt, step_req, clear_fault,
        output door_ready, cnt_a, cnt_b, fault, step_done, system_vec
    );
endinterface

// File: rtl/door_step_scheduler.sv
// Door step scheduler: accumulates per-door enter/exit events over an epoch.
// At the end of each epoch it commits one step of the two-room occupancy monitor.
// A step is rejected, and a fault latched, when room A would hold fewer people than room B.
module door_step_scheduler #(
    parameter int NDOORS  = 3,
    parameter int WORDLEN = 10,
    parameter int EPOCH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    door_step_if.slave bus
);
    localparam int TW = $clog2(EPOCH);
    localparam logic [WORDLEN-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {ST_ACCUM, ST_COMMIT, ST_FAULT} state_t;

    // Per-door counters are indexed by event code.
    // 0 = enterA, 1 = exitA, 2 = enterB, 3 = exitB.
    state_t             r_state;
    state_t             w_state_next;
    logic [WORDLEN-1:0] r_evt_cnt [NDOORS][4];
    logic [WORDLEN-1:0] w_evt_inc [NDOORS][4];
    logic [TW-1:0]      r_timer;
    logic [WORDLEN-1:0] r_cnt_a;
    logic [WORDLEN-1:0] r_cnt_b;
    logic [WORDLEN-1:0] w_next_a;
    logic [WORDLEN-1:0] w_next_b;
    logic               r_fault;
    logic               r_step_done;
    logic               w_ready;
    logic [NDOORS-1:0]  w_accept;
    logic               w_overflow;
    logic               w_step_ok;

    assign w_ready  = (r_state == ST_ACCUM);
    assign w_accept = bus.door_valid & {NDOORS{w_ready}};

    genvar gi, gj;
    generate
        for (gi = 0; gi < NDOORS; gi++) begin : g_door
            for (gj = 0; gj < 4; gj++) begin : g_field
                assign w_evt_inc[gi][gj] = r_evt_cnt[gi][gj] +
                    WORDLEN'(w_accept[gi] && (bus.door_evt[2*gi +: 2] == 2'(gj)));
                // The system vector lists the fields as {enteredA, exitedA, enteredB, exitedB}, MSB first.
                assign bus.system_vec[4*WORDLEN*gi + (3-gj)*WORDLEN +: WORDLEN] = r_evt_cnt[gi][gj];
            end
        end
    endgenerate

    // Overflow guard: stop the epoch before any field could wrap.
    always_comb begin
        w_overflow = 1'b0;
        for (int d = 0; d < NDOORS; d++) begin
            for (int f = 0; f < 4; f++) begin
                if (w_evt_inc[d][f] == ALL_ONES) begin
                    w_overflow = 1'b1;
                end
            end
        end
    end

    // Candidate monitor step, accumulated door 0 first with modulo-2^WORDLEN arithmetic.
    always_comb begin
        w_next_a = r_cnt_a;
        w_next_b = r_cnt_b;
        for (int d = 0; d < NDOORS; d++) begin
            w_next_a = w_next_a + r_evt_cnt[d][0] - r_evt_cnt[d][1];
            w_next_b = w_next_b + r_evt_cnt[d][2] - r_evt_cnt[d][3];
        end
        w_step_ok = !(w_next_a < w_next_b);
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: begin
                if ((r_timer == TW'(EPOCH-1)) || bus.step_req || w_overflow) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_state_next = w_step_ok ? ST_ACCUM : ST_FAULT;
            end
            ST_FAULT: begin
                if (bus.clear_fault) begin
                    w_state_next = ST_ACCUM;
                end
            end
            default: w_state_next = ST_ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: event counters, epoch timer, committed counts and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < NDOORS; d++) begin
                for (int f = 0; f < 4; f++) begin
                    r_evt_cnt[d][f] <= '0;
                end
            end
            r_timer     <= '0;
            r_cnt_a     <= '0;
            r_cnt_b     <= '0;
            r_fault     <= 1'b0;
            r_step_done <= 1'b0;
        end else begin
            r_step_done <= 1'b0;
            case (r_state)
                ST_ACCUM: begin
                    r_evt_cnt <= w_evt_inc;
                    r_timer   <= r_timer + 1'b1;
                end
                ST_COMMIT: begin
                    if (w_step_ok) begin
                        r_cnt_a     <= w_next_a;
                        r_cnt_b     <= w_next_b;
                        r_step_done <= 1'b1;
                        r_timer     <= '0;
                        for (int d = 0; d < NDOORS; d++) begin
                            for (int f = 0; f < 4; f++) begin
                                r_evt_cnt[d][f] <= '0;
                            end
                        end
                    end else begin
                        // Keep the offending counts visible for debug.
                        r_fault <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (bus.clear_fault) begin
                        r_fault <= 1'b0;
                        r_timer <= '0;
                        for (int d = 0; d < NDOORS; d++) begin
                            for (int f = 0; f < 4; f++) begin
                                r_evt_cnt[d][f] <= '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.door_ready = {NDOORS{w_ready}};
    assign bus.cnt_a      = r_cnt_a;
    assign bus.cnt_b      = r_cnt_b;
    assign bus.fault      = r_fault;
    assign bus.step_done  = r_step_done;
endmodule
